// File: rtl/kernel_sequencer.sv
// Owns the active 3x3 convolution kernel. Requested changes are loaded into a
// shadow bank one tap per cycle and swapped in only at a frame boundary.
module kernel_sequencer #(
  parameter int unsigned NUM_KERNELS    = 6,
  parameter int unsigned DEFAULT_KERNEL = 0
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         next_in,
  input  logic                         prev_in,
  input  logic                         sel_valid_in,
  input  logic [2:0]                   sel_in,
  input  logic                         frame_start_in,
  output logic signed [2:0][2:0][7:0]  coeffs_out,
  output logic signed [7:0]            shift_out,
  output logic [2:0]                   active_idx_out,
  output logic                         pending_out,
  output logic                         swap_out
);

  localparam int unsigned IDX_W    = 3;
  localparam int unsigned COEF_W   = 8;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned NUM_TAPS = 9;

  localparam logic [IDX_W-1:0] DEF_IDX  = IDX_W'(DEFAULT_KERNEL);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_KERNELS - 1);
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(NUM_TAPS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_READY = 2'd2
  } state_t;

  // Kernel table lookup; unknown indices read as Identity.
  function automatic logic signed [2:0][2:0][COEF_W-1:0] f_kernel(input logic [IDX_W-1:0] idx);
    int v [9];
    logic signed [2:0][2:0][COEF_W-1:0] k;
    case (idx)
      3'd1:    v = '{ 1,  2,  1,  2, 4,  2,  1,  2,  1};
      3'd2:    v = '{ 0, -1,  0, -1, 5, -1,  0, -1,  0};
      3'd3:    v = '{-1, -1, -1, -1, 8, -1, -1, -1, -1};
      3'd4:    v = '{ 1,  0, -1,  2, 0, -2,  1,  0, -1};
      3'd5:    v = '{-1, -2, -1,  0, 0,  0,  1,  2,  1};
      default: v = '{ 0,  0,  0,  0, 1,  0,  0,  0,  0};
    endcase
    for (int i = 0; i < 9; i++) begin
      k[2'(i / 3)][2'(i % 3)] = COEF_W'(v[i]);
    end
    return k;
  endfunction

  function automatic logic signed [COEF_W-1:0] f_shift(input logic [IDX_W-1:0] idx);
    return (idx == 3'd1) ? 8'sd4 : 8'sd0;
  endfunction

  state_t                              r_state;
  logic [CNT_W-1:0]                    r_cnt;
  logic [IDX_W-1:0]                    r_target;
  logic [IDX_W-1:0]                    r_active_idx;
  logic signed [2:0][2:0][COEF_W-1:0]  r_shadow;
  logic signed [COEF_W-1:0]            r_shadow_shift;
  logic signed [2:0][2:0][COEF_W-1:0]  r_active;
  logic signed [COEF_W-1:0]            r_active_shift;
  logic                                r_pending;
  logic                                r_swap;

  state_t                              w_state_nxt;
  logic [CNT_W-1:0]                    w_cnt_nxt;
  logic                                w_req_valid;
  logic [IDX_W-1:0]                    w_req_idx;
  logic                                w_tap_we;
  logic                                w_shift_we;
  logic                                w_swap;
  logic [1:0]                          w_row;
  logic [1:0]                          w_col;
  logic signed [2:0][2:0][COEF_W-1:0]  w_tbl;

  // Request decode: direct select beats next/prev; next+prev together cancel.
  always_comb begin
    w_req_valid = 1'b0;
    w_req_idx   = r_target;
    if (sel_valid_in) begin
      if (32'(sel_in) < NUM_KERNELS) begin
        w_req_valid = 1'b1;
        w_req_idx   = sel_in;
      end
    end else if (next_in ^ prev_in) begin
      w_req_valid = 1'b1;
      if (next_in) begin
        w_req_idx = (r_target == LAST_IDX) ? 3'd0 : r_target + 3'd1;
      end else begin
        w_req_idx = (r_target == 3'd0) ? LAST_IDX : r_target - 3'd1;
      end
    end
  end

  assign w_tbl = f_kernel(r_target);
  assign w_row = 2'(r_cnt / 4'd3);
  assign w_col = 2'(r_cnt % 4'd3);

  // Next-state: any valid request restarts the load, or aborts if it lands on the active kernel.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tap_we    = 1'b0;
    w_shift_we  = 1'b0;
    w_swap      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req_valid && (w_req_idx != r_active_idx)) begin
          w_state_nxt = S_LOAD;
          w_cnt_nxt   = '0;
        end
      end
      S_LOAD: begin
        if (w_req_valid) begin
          w_state_nxt = (w_req_idx == r_active_idx) ? S_IDLE : S_LOAD;
          w_cnt_nxt   = '0;
        end else begin
          w_tap_we = 1'b1;
          if (r_cnt == LAST_TAP) begin
            w_shift_we  = 1'b1;
            w_state_nxt = S_READY;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end
      end
      S_READY: begin
        if (w_req_valid) begin
          w_state_nxt = (w_req_idx == r_active_idx) ? S_IDLE : S_LOAD;
          w_cnt_nxt   = '0;
        end else if (frame_start_in) begin
          w_swap      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_target       <= DEF_IDX;
      r_active_idx   <= DEF_IDX;
      r_shadow       <= f_kernel(DEF_IDX);
      r_shadow_shift <= f_shift(DEF_IDX);
      r_active       <= f_kernel(DEF_IDX);
      r_active_shift <= f_shift(DEF_IDX);
      r_pending      <= 1'b0;
      r_swap         <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pending <= (w_state_nxt != S_IDLE);
      r_swap    <= w_swap;
      if (w_req_valid) begin
        r_target <= w_req_idx;
      end
      if (w_tap_we) begin
        r_shadow[w_row][w_col] <= w_tbl[w_row][w_col];
      end
      if (w_shift_we) begin
        r_shadow_shift <= f_shift(r_target);
      end
      if (w_swap) begin
        r_active       <= r_shadow;
        r_active_shift <= r_shadow_shift;
        r_active_idx   <= r_target;
      end
    end
  end

  assign coeffs_out     = r_active;
  assign shift_out      = r_active_shift;
  assign active_idx_out = r_active_idx;
  assign pending_out    = r_pending;
  assign swap_out       = r_swap;

endmodule

// File: tb/tb_kernel_sequencer.sv
// Scoreboard bench for kernel_sequencer: directed scenarios then random pulses,
// checked against a cycle-level model of request/latency/frame rules.
module tb_kernel_sequencer;

  logic                        clk_in = 1'b0;
  logic                        rst_in;
  logic                        next_in;
  logic                        prev_in;
  logic                        sel_valid_in;
  logic [2:0]                  sel_in;
  logic                        frame_start_in;
  logic signed [2:0][2:0][7:0] coeffs_out;
  logic signed [7:0]           shift_out;
  logic [2:0]                  active_idx_out;
  logic                        pending_out;
  logic                        swap_out;

  always #5 clk_in = ~clk_in;

  kernel_sequencer #(.NUM_KERNELS(6), .DEFAULT_KERNEL(0)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .next_in        (next_in),
    .prev_in        (prev_in),
    .sel_valid_in   (sel_valid_in),
    .sel_in         (sel_in),
    .frame_start_in (frame_start_in),
    .coeffs_out     (coeffs_out),
    .shift_out      (shift_out),
    .active_idx_out (active_idx_out),
    .pending_out    (pending_out),
    .swap_out       (swap_out)
  );

  // Row-major coefficients followed by shift.
  int K [6][10] = '{
    '{ 0,  0,  0,  0, 1,  0,  0,  0,  0, 0},
    '{ 1,  2,  1,  2, 4,  2,  1,  2,  1, 4},
    '{ 0, -1,  0, -1, 5, -1,  0, -1,  0, 0},
    '{-1, -1, -1, -1, 8, -1, -1, -1, -1, 0},
    '{ 1,  0, -1,  2, 0, -2,  1,  0, -1, 0},
    '{-1, -2, -1,  0, 0,  0,  1,  2,  1, 0}
  };

  typedef struct {
    int tag;
    int idx;
    bit pend;
    bit swap;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Model state: active kernel, requested kernel, change in flight, earliest frame cycle.
  int m_active = 0;
  int m_target = 0;
  bit m_pend   = 1'b0;
  int m_ready  = 0;

  always @(posedge clk_in) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic check_outputs(input int idx, input bit pend, input bit swp);
    int v;
    chk("active_idx", int'(active_idx_out), idx);
    chk("pending", int'(pending_out), int'(pend));
    chk("swap", int'(swap_out), int'(swp));
    chk("shift", int'(shift_out), K[idx][9]);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        v = int'($signed(coeffs_out[r][c]));
        chk($sformatf("coef_%0d_%0d", r, c), v, K[idx][r*3+c]);
      end
    end
  endtask

  // Monitor: compare the outputs of each cycle against the expectation tagged for it.
  always @(negedge clk_in) begin
    exp_t e;
    if (q.size() > 0 && q[0].tag == cyc) begin
      e = q.pop_front();
      check_outputs(e.idx, e.pend, e.swap);
    end
  end

  task automatic step(input bit n, input bit p, input bit sv, input int s, input bit f);
    int  t;
    bit  valid;
    bit  swp;
    exp_t e;
    @(posedge clk_in);
    #2;
    next_in        = n;
    prev_in        = p;
    sel_valid_in   = sv;
    sel_in         = 3'(s);
    frame_start_in = f;
    valid = 1'b0;
    t     = m_target;
    swp   = 1'b0;
    if (sv) begin
      if (s < 6) begin
        valid = 1'b1;
        t     = s;
      end
    end else if (n != p) begin
      valid = 1'b1;
      t     = n ? (m_target + 1) % 6 : (m_target + 5) % 6;
    end
    if (valid) begin
      m_target = t;
      if (t == m_active) begin
        m_pend = 1'b0;
      end else begin
        m_pend  = 1'b1;
        m_ready = cyc + 10;
      end
    end else if (m_pend && f && cyc >= m_ready) begin
      m_active = m_target;
      m_pend   = 1'b0;
      swp      = 1'b1;
    end
    e.tag  = cyc + 1;
    e.idx  = m_active;
    e.pend = m_pend;
    e.swap = swp;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    exp_t e;
    @(posedge clk_in);
    #2;
    q.delete();
    rst_in         = 1'b0;
    next_in        = 1'b0;
    prev_in        = 1'b0;
    sel_valid_in   = 1'b0;
    sel_in         = 3'd0;
    frame_start_in = 1'b0;
    m_active = 0;
    m_target = 0;
    m_pend   = 1'b0;
    #1;
    check_outputs(0, 1'b0, 1'b0);
    repeat (2) @(posedge clk_in);
    #2;
    rst_in = 1'b1;
    e.tag  = cyc + 1;
    e.idx  = 0;
    e.pend = 1'b0;
    e.swap = 1'b0;
    q.push_back(e);
  endtask

  initial begin
    rst_in         = 1'b0;
    next_in        = 1'b0;
    prev_in        = 1'b0;
    sel_valid_in   = 1'b0;
    sel_in         = 3'd0;
    frame_start_in = 1'b0;
    do_reset();
    idle(2);

    // Wrap downwards 0 -> 5, then upwards 5 -> 0.
    step(0, 1, 0, 0, 0); idle(12); step(0, 0, 0, 0, 1); idle(3);
    step(1, 0, 0, 0, 0); idle(12); step(0, 0, 0, 0, 1); idle(3);

    // next then frame 20 cycles later -> Gaussian.
    step(1, 0, 0, 0, 0); idle(19); step(0, 0, 0, 0, 1); idle(3);

    // Frame during LOAD is ignored; a later frame swaps.
    step(0, 1, 0, 0, 0); idle(4); step(0, 0, 0, 0, 1); idle(24); step(0, 0, 0, 0, 1); idle(3);

    // Select 2 then 4 mid-load: only SobelX becomes active.
    step(0, 0, 1, 2, 0); idle(2); step(0, 0, 1, 4, 0); idle(15); step(0, 0, 0, 0, 1); idle(3);

    // Out-of-range select and next+prev together are ignored.
    step(0, 0, 1, 7, 0); idle(3);
    step(1, 1, 0, 0, 0); idle(3);

    // Select back to the active kernel while READY aborts; the frame then does nothing.
    step(0, 0, 1, 3, 0); idle(12); step(0, 0, 1, 4, 0); idle(2); step(0, 0, 0, 0, 1); idle(3);

    // Request racing a frame in READY: the request wins.
    step(0, 0, 1, 1, 0); idle(11); step(1, 0, 0, 0, 1); idle(12); step(0, 0, 0, 0, 1); idle(3);

    // Reset in the middle of a load.
    step(1, 0, 0, 0, 0); idle(4); do_reset(); idle(3);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 3),
             ($urandom_range(0, 99) < 3), int'($urandom_range(0, 7)),
             ($urandom_range(0, 99) < 5));
      end
    end
    idle(3);
    @(posedge clk_in);
    #6;
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
